// File: rtl/axi_lite_xbar.sv
// axi_lite_xbar: 1-master, 3-slave AXI4-Lite address-decoding crossbar (s0 DRAM, s1 UART, s2 CLINT).
// Define XBAR_PERF_EN to add per-slave read/write completion counters and a DECERR counter.
module axi_lite_xbar #(
    parameter logic [31:0] DRAM_BASE  = 32'h8000_0000,
    parameter logic [31:0] DRAM_MASK  = 32'hF800_0000,
    parameter logic [31:0] UART_BASE  = 32'ha000_03f8,
    parameter logic [31:0] UART_MASK  = 32'hFFFF_FFF8,
    parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_FFF8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef XBAR_PERF_EN
    output logic [95:0] perf_rd_cnt,
    output logic [95:0] perf_wr_cnt,
    output logic [31:0] perf_err_cnt,
`endif
    input  logic [31:0] m_araddr,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rvalid,
    input  logic        m_rready,
    input  logic [31:0] m_awaddr,
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    input  logic        m_wvalid,
    output logic        m_wready,
    output logic [1:0]  m_bresp,
    output logic        m_bvalid,
    input  logic        m_bready,
    output logic [95:0] s_araddr,
    output logic [2:0]  s_arvalid,
    input  logic [2:0]  s_arready,
    input  logic [95:0] s_rdata,
    input  logic [5:0]  s_rresp,
    input  logic [2:0]  s_rvalid,
    output logic [2:0]  s_rready,
    output logic [95:0] s_awaddr,
    output logic [2:0]  s_awvalid,
    input  logic [2:0]  s_awready,
    output logic [95:0] s_wdata,
    output logic [11:0] s_wstrb,
    output logic [2:0]  s_wvalid,
    input  logic [2:0]  s_wready,
    input  logic [5:0]  s_bresp,
    input  logic [2:0]  s_bvalid,
    output logic [2:0]  s_bready
);
    localparam logic [1:0] NONE = 2'd3;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_ERR} wr_state_t;

    function automatic logic [1:0] decode(input logic [31:0] a);
        return ((a & UART_MASK) == UART_BASE)   ? 2'd1 :
               ((a & CLINT_MASK) == CLINT_BASE) ? 2'd2 :
               ((a & DRAM_MASK) == DRAM_BASE)   ? 2'd0 : NONE;
    endfunction

    rd_state_t   rd_state_q, rd_state_d;
    wr_state_t   wr_state_q, wr_state_d;
    logic [1:0]  rd_sel_q, rd_sel_d, wr_sel_q, wr_sel_d;
    logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            rd_sel_q   <= '0;
            wr_sel_q   <= '0;
            araddr_q   <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_sel_q   <= rd_sel_d;
            wr_sel_q   <= wr_sel_d;
            araddr_q   <= araddr_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_sel_d   = rd_sel_q;
        araddr_d   = araddr_q;
        case (rd_state_q)
            R_IDLE: if (m_arvalid) begin
                araddr_d   = m_araddr;
                rd_sel_d   = decode(m_araddr);
                rd_state_d = (decode(m_araddr) == NONE) ? R_ERR : R_ADDR;
            end
            R_ADDR: if (s_arready[rd_sel_q]) rd_state_d = R_DATA;
            R_DATA: if (s_rvalid[rd_sel_q] && m_rready) rd_state_d = R_IDLE;
            default: if (m_rready) rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        m_arready = (rd_state_q == R_IDLE);
        s_araddr  = {3{araddr_q}};
        s_arvalid = '0;
        s_rready  = '0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        if (rd_state_q == R_ADDR) s_arvalid[rd_sel_q] = 1'b1;
        if (rd_state_q == R_DATA) begin
            s_rready[rd_sel_q] = m_rready;
            m_rvalid = s_rvalid[rd_sel_q];
            m_rdata  = s_rdata[{rd_sel_q, 5'd0} +: 32];
            m_rresp  = s_rresp[{rd_sel_q, 1'b0} +: 2];
        end
        if (rd_state_q == R_ERR) begin
            m_rvalid = 1'b1;
            m_rresp  = 2'b11;
        end
    end

    // AW and W are only taken together; each slave-side valid then retires on its own ready.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_sel_d   = wr_sel_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            W_IDLE: if (m_awvalid && m_wvalid) begin
                awaddr_d   = m_awaddr;
                wdata_d    = m_wdata;
                wstrb_d    = m_wstrb;
                wr_sel_d   = decode(m_awaddr);
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
                wr_state_d = (decode(m_awaddr) == NONE) ? W_ERR : W_REQ;
            end
            W_REQ: begin
                aw_done_d  = aw_done_q | s_awready[wr_sel_q];
                w_done_d   = w_done_q | s_wready[wr_sel_q];
                wr_state_d = (aw_done_d && w_done_d) ? W_RESP : W_REQ;
            end
            W_RESP: if (s_bvalid[wr_sel_q] && m_bready) wr_state_d = W_IDLE;
            default: if (m_bready) wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        m_awready = (wr_state_q == W_IDLE) && m_awvalid && m_wvalid;
        m_wready  = m_awready;
        s_awaddr  = {3{awaddr_q}};
        s_wdata   = {3{wdata_q}};
        s_wstrb   = {3{wstrb_q}};
        s_awvalid = '0;
        s_wvalid  = '0;
        s_bready  = '0;
        m_bvalid  = 1'b0;
        m_bresp   = '0;
        if (wr_state_q == W_REQ) begin
            s_awvalid[wr_sel_q] = !aw_done_q;
            s_wvalid[wr_sel_q]  = !w_done_q;
        end
        if (wr_state_q == W_RESP) begin
            s_bready[wr_sel_q] = m_bready;
            m_bvalid = s_bvalid[wr_sel_q];
            m_bresp  = s_bresp[{wr_sel_q, 1'b0} +: 2];
        end
        if (wr_state_q == W_ERR) begin
            m_bvalid = 1'b1;
            m_bresp  = 2'b11;
        end
    end

`ifdef XBAR_PERF_EN
    logic [95:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d;
    logic [31:0] perf_err_q, perf_err_d;
    logic        rd_done, wr_done, rd_err, wr_err;
    always_comb begin
        rd_done    = (rd_state_q == R_DATA) && s_rvalid[rd_sel_q] && m_rready;
        wr_done    = (wr_state_q == W_RESP) && s_bvalid[wr_sel_q] && m_bready;
        rd_err     = (rd_state_q == R_ERR) && m_rready;
        wr_err     = (wr_state_q == W_ERR) && m_bready;
        perf_rd_d  = perf_rd_q;
        perf_wr_d  = perf_wr_q;
        perf_err_d = perf_err_q + 32'(rd_err) + 32'(wr_err);
        if (rd_done) perf_rd_d[{rd_sel_q, 5'd0} +: 32] = perf_rd_q[{rd_sel_q, 5'd0} +: 32] + 32'd1;
        if (wr_done) perf_wr_d[{wr_sel_q, 5'd0} +: 32] = perf_wr_q[{wr_sel_q, 5'd0} +: 32] + 32'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_rd_q  <= '0;
            perf_wr_q  <= '0;
            perf_err_q <= '0;
        end else begin
            perf_rd_q  <= perf_rd_d;
            perf_wr_q  <= perf_wr_d;
            perf_err_q <= perf_err_d;
        end
    end
    assign perf_rd_cnt  = perf_rd_q;
    assign perf_wr_cnt  = perf_wr_q;
    assign perf_err_cnt = perf_err_q;
`endif
endmodule

// File: tb/tb_axi_lite_xbar.sv
// tb_axi_lite_xbar: randomized and directed checks of axi_lite_xbar against an address-range reference model.
module tb_axi_lite_xbar;
    logic clk = 1'b0, rst;
    always #5 clk = ~clk;

    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic        m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;
    logic [95:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [2:0]  s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic [2:0]  s_wvalid, s_wready, s_bvalid, s_bready;
    logic [5:0]  s_rresp, s_bresp;
    logic [11:0] s_wstrb;

    axi_lite_xbar dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference memory map as inclusive address ranges, UART before CLINT before DRAM; 3 = unmapped.
    function automatic int ref_slave(input logic [31:0] a);
        if (a >= 32'ha000_03f8 && a <= 32'ha000_03ff) return 1;
        if (a >= 32'ha000_0048 && a <= 32'ha000_004f) return 2;
        if (a >= 32'h8000_0000 && a <= 32'h87ff_ffff) return 0;
        return 3;
    endfunction

    function automatic logic [31:0] slv_rdata(input int i, input logic [31:0] a);
        if (i == 0 && a == 32'h8000_0010) return 32'hdead_beef;
        return a ^ (32'h1357_9bdf * 32'(i + 1));
    endfunction

    function automatic logic [1:0] slv_rresp(input int i, input logic [31:0] a);
        return a[3:2] ^ 2'(i);
    endfunction

    function automatic logic [2:0] oh(input int i);
        return (i < 3) ? 3'(1 << i) : 3'b000;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000 | (r & 32'h07ff_fffc);
            1: return 32'ha000_03f8 + 32'(r[2:0]);
            2: return 32'ha000_0048 + 32'(r[2:0]);
            3: begin
                logic [31:0] near [4] = '{32'ha000_0400, 32'h8800_0000, 32'ha000_0040, 32'h7fff_fffc};
                return near[r[1:0]];
            end
            default: return r;
        endcase
    endfunction

    bit          fast, no_ar;
    int          rd_bp;
    bit          rd_act, rd_ph, rd_ars, wr_act, wr_ph, wr_aws, wr_ws, prv_hold;
    logic [31:0] rd_addr, wr_addr, wr_data, prv_rdata;
    logic [3:0]  wr_strb;
    int          rd_exp, wr_exp, rd_lat, lat_done;
    bit          rpend [3], awg [3], wg [3], bpend [3];
    int          rdly [3], bdly [3];
    logic [31:0] raddr_s [3], wdat_s [3];

    task automatic clear_tb();
        rd_act = 0; rd_ph = 0; rd_ars = 0; wr_act = 0; wr_ph = 0; wr_aws = 0; wr_ws = 0;
        prv_hold = 0; rd_bp = 0;
        for (int i = 0; i < 3; i++) begin
            rpend[i] = 0; awg[i] = 0; wg[i] = 0; bpend[i] = 0; rdly[i] = 0; bdly[i] = 0;
        end
        m_arvalid = 0; m_rready = 0; m_awvalid = 0; m_wvalid = 0; m_bready = 0;
    endtask

    // One clock: drive at negedge, check DUT outputs 1ns later, then advance both bench-side models.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            s_arready[i] = no_ar ? 1'b0 : (fast ? 1'b1 : 1'($urandom_range(0, 1)));
            s_awready[i] = fast ? 1'b1 : 1'($urandom_range(0, 1));
            s_wready[i]  = fast ? 1'b1 : 1'($urandom_range(0, 1));
            s_rvalid[i]  = rpend[i] ? (rdly[i] == 0) : (!fast && $urandom_range(0, 3) == 0);
            s_rdata[32*i +: 32] = rpend[i] ? slv_rdata(i, raddr_s[i]) : $urandom;
            s_rresp[2*i +: 2]   = rpend[i] ? slv_rresp(i, raddr_s[i]) : 2'($urandom);
            s_bvalid[i]  = bpend[i] ? (bdly[i] == 0) : (!fast && $urandom_range(0, 3) == 0);
            s_bresp[2*i +: 2]   = bpend[i] ? wdat_s[i][5:4] : 2'($urandom);
        end
        m_araddr  = rd_addr;
        m_arvalid = rd_act && !rd_ph;
        m_rready  = rd_act && rd_ph && rd_bp == 0 && (fast || $urandom_range(0, 1) == 1);
        m_awaddr  = wr_addr;
        m_wdata   = wr_data;
        m_wstrb   = wr_strb;
        m_awvalid = wr_act && !wr_ph;
        m_wvalid  = wr_act && !wr_ph;
        m_bready  = wr_act && wr_ph && (fast || $urandom_range(0, 1) == 1);
        #1;
        if (prv_hold) begin
            chk("r_hold_valid", 32'(m_rvalid), 1);
            chk("r_hold_data", m_rdata, prv_rdata);
        end
        chk("m_arready", 32'(m_arready), 32'(!(rd_act && rd_ph)));
        chk("m_awready", 32'(m_awready), 32'(m_awvalid));
        chk("m_wready", 32'(m_wready), 32'(m_awvalid));
        chk("s_arvalid", 32'(s_arvalid), 32'((rd_act && rd_ph && !rd_ars) ? oh(rd_exp) : 3'b0));
        chk("s_rready", 32'(s_rready), 32'((rd_act && rd_ph && rd_ars && m_rready) ? oh(rd_exp) : 3'b0));
        chk("m_rvalid", 32'(m_rvalid),
            32'((rd_act && rd_ph) ? (rd_exp == 3 ? 1'b1 : (rd_ars & s_rvalid[rd_exp])) : 1'b0));
        chk("s_awvalid", 32'(s_awvalid), 32'((wr_act && wr_ph && !wr_aws) ? oh(wr_exp) : 3'b0));
        chk("s_wvalid", 32'(s_wvalid), 32'((wr_act && wr_ph && !wr_ws) ? oh(wr_exp) : 3'b0));
        chk("s_bready", 32'(s_bready),
            32'((wr_act && wr_ph && wr_aws && wr_ws && m_bready) ? oh(wr_exp) : 3'b0));
        chk("m_bvalid", 32'(m_bvalid),
            32'((wr_act && wr_ph) ? (wr_exp == 3 ? 1'b1 : (wr_aws & wr_ws & s_bvalid[wr_exp])) : 1'b0));
        prv_hold  = rd_act && m_rvalid && !m_rready;
        prv_rdata = m_rdata;
        if (rd_act && rd_ph) rd_lat++;
        if (rd_bp > 0 && m_rvalid) rd_bp--;
        for (int i = 0; i < 3; i++) begin
            if (rpend[i] && rdly[i] > 0) rdly[i]--;
            if (s_rvalid[i] && s_rready[i]) rpend[i] = 0;
            if (s_arvalid[i] && s_arready[i]) begin
                chk("ar_slave", i, rd_exp);
                chk("ar_addr", s_araddr[32*i +: 32], rd_addr);
                rd_ars = 1; rpend[i] = 1; raddr_s[i] = s_araddr[32*i +: 32];
                rdly[i] = fast ? 0 : int'($urandom_range(0, 3));
            end
            if (s_awvalid[i] && s_awready[i]) begin
                chk("aw_addr", s_awaddr[32*i +: 32], wr_addr);
                awg[i] = 1; wr_aws = 1;
            end
            if (s_wvalid[i] && s_wready[i]) begin
                chk("w_data", s_wdata[32*i +: 32], wr_data);
                chk("w_strb", 32'(s_wstrb[4*i +: 4]), 32'(wr_strb));
                wg[i] = 1; wr_ws = 1; wdat_s[i] = s_wdata[32*i +: 32];
            end
            if (bpend[i] && bdly[i] > 0) bdly[i]--;
            if (s_bvalid[i] && s_bready[i]) bpend[i] = 0;
            if (awg[i] && wg[i]) begin
                awg[i] = 0; wg[i] = 0; bpend[i] = 1;
                bdly[i] = fast ? 0 : int'($urandom_range(0, 3));
            end
        end
        if (m_rvalid && m_rready) begin
            chk("r_data", m_rdata, rd_exp < 3 ? slv_rdata(rd_exp, rd_addr) : 32'h0);
            chk("r_resp", 32'(m_rresp), 32'(rd_exp < 3 ? slv_rresp(rd_exp, rd_addr) : 2'b11));
            lat_done = rd_lat; rd_act = 0; prv_hold = 0;
        end
        if (m_arvalid && m_arready) begin rd_ph = 1; rd_lat = 0; end
        if (m_bvalid && m_bready) begin
            chk("b_resp", 32'(m_bresp), 32'(wr_exp < 3 ? wr_data[5:4] : 2'b11));
            wr_act = 0;
        end
        if (m_awvalid && m_awready) wr_ph = 1;
    endtask

    task automatic run(input bit do_rd, input logic [31:0] ra, input bit do_wr,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
        rd_act = do_rd; rd_ph = 0; rd_ars = 0; rd_addr = ra; rd_exp = ref_slave(ra);
        wr_act = do_wr; wr_ph = 0; wr_aws = 0; wr_ws = 0;
        wr_addr = wa; wr_data = wd; wr_strb = ws; wr_exp = ref_slave(wa);
        for (int n = 0; n < 300 && (rd_act || wr_act); n++) cycle();
        chk("txn_timeout", 32'({rd_act, wr_act}), 0);
        if (rd_act || wr_act) begin
            rst = 1; clear_tb(); @(negedge clk); rst = 0;
        end
    endtask

    initial begin
        rst = 1; fast = 0; no_ar = 0; lat_done = 0;
        rd_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0; rd_exp = 3; wr_exp = 3; rd_lat = 0;
        clear_tb();
        m_araddr = 0; m_awaddr = 0; m_wdata = 0; m_wstrb = 0;
        s_arready = 0; s_rdata = 0; s_rresp = 0; s_rvalid = 0; s_awready = 0;
        s_wready = 0; s_bresp = 0; s_bvalid = 0;
        #12;
        chk("rst_m_arready", 32'(m_arready), 1);
        chk("rst_m_awready", 32'({m_awready, m_wready}), 0);
        chk("rst_m_valids", 32'({m_rvalid, m_bvalid}), 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_resps", 32'({m_rresp, m_bresp}), 0);
        chk("rst_s_valids", 32'({s_arvalid, s_awvalid, s_wvalid}), 0);
        chk("rst_s_readies", 32'({s_rready, s_bready}), 0);
        chk("rst_s_araddr", s_araddr[31:0] | s_araddr[95:64], 0);
        @(negedge clk); rst = 0;

        fast = 1;
        run(1, 32'h8000_0010, 0, 0, 0, 0);
        chk("rd_latency", lat_done, 2);
        fast = 0;
        run(0, 0, 1, 32'ha000_03f8, 32'h41, 4'b0001);
        run(1, 32'h0000_1000, 0, 0, 0, 0);
        run(0, 0, 1, 32'h0000_1000, 32'h30, 4'hf);
        fast = 1;
        run(1, 32'ha000_0048, 1, 32'h8000_0100, 32'h1234_5678, 4'hf);
        rd_bp = 5;
        run(1, 32'h8000_0040, 0, 0, 0, 0);
        chk("bp_cycles_used", rd_bp, 0);

        fast = 0; no_ar = 1;
        rd_act = 1; rd_ph = 0; rd_ars = 0; rd_addr = 32'h8000_0020; rd_exp = 0;
        repeat (3) cycle();
        chk("pre_rst_arvalid", 32'(s_arvalid), 32'h1);
        #2 rst = 1;
        #1;
        chk("mid_rst_arvalid", 32'(s_arvalid), 0);
        chk("mid_rst_arready", 32'(m_arready), 1);
        clear_tb();
        @(negedge clk); rst = 0; no_ar = 0;
        run(1, 32'h8000_0020, 0, 0, 0, 0);

        for (int k = 0; k < 150; k++) begin
            bit dr = 1'($urandom_range(0, 1));
            bit dw = !dr || $urandom_range(0, 1) == 1;
            run(dr, rand_addr(), dw, rand_addr(), $urandom, 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
